// File: rtl/spi_codec_config_sequencer.sv
// Walks the codec register table and issues one SPI transaction per entry via spi_master.
// Define SPI_CODEC_READBACK_EN to read back and verify entries 3-7 after each write.
module spi_codec_config_sequencer #(
  parameter int unsigned SPI_DATA_WIDTH = 32,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [SPI_DATA_WIDTH-1:0] i_data,
  input  logic                      i_done,
  input  logic                      i_busy,
  output logic                      o_enable,
  output logic [SPI_DATA_WIDTH-1:0] o_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic [1:0]                o_error_code,
  output logic [2:0]                o_error_index
);

  localparam int unsigned GW = $clog2(GAP_CYCLES + 2);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_GAP, S_FINISH
`ifdef SPI_CODEC_READBACK_EN
    , S_CHECK
`endif
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  logic                      rd_q, rd_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic [TW-1:0]             to_q, to_d;
  logic [SPI_DATA_WIDTH-1:0] data_q, data_d;
  logic                      err_q, err_d;
  logic [1:0]                code_q, code_d;
  logic [2:0]                eidx_q, eidx_d;
  logic                      start_q, arm_q;
  logic                      start_edge;
  logic                      to_gap, advance;
  logic [23:0]               entry_w;
  logic                      unused_data;
`ifdef SPI_CODEC_READBACK_EN
  logic [7:0]                rbyte_q, rbyte_d;
`endif

  function automatic logic [23:0] table_entry(input logic [2:0] i);
    case (i)
      3'd3:    table_entry = {16'h4000, 8'h01};
      3'd4:    table_entry = {16'h4015, 8'h01};
      3'd5:    table_entry = {16'h4019, 8'h03};
      3'd6:    table_entry = {16'h402A, 8'h03};
      3'd7:    table_entry = {16'h40F9, 8'h7F};
      default: table_entry = {16'h4000, 8'h00};
    endcase
  endfunction

  assign entry_w     = table_entry(idx_q);
  assign unused_data = ^i_data;
  // arm_q blocks a start that was already high when reset released
  assign start_edge  = i_start & ~start_q & arm_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rd_d     = rd_q;
    gap_d    = gap_q;
    to_d     = to_q;
    data_d   = data_q;
    err_d    = err_q;
    code_d   = code_q;
    eidx_d   = eidx_q;
    to_gap   = 1'b0;
    advance  = 1'b0;
    o_enable = 1'b0;
`ifdef SPI_CODEC_READBACK_EN
    rbyte_d  = rbyte_q;
`endif
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (start_edge) begin
          err_d   = 1'b0;
          code_d  = 2'b00;
          eidx_d  = 3'd0;
          idx_d   = 3'd0;
          rd_d    = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        data_d       = '0;
        data_d[31:0] = {7'b0, rd_q, entry_w[23:8], rd_q ? 8'h00 : entry_w[7:0]};
        state_d      = S_ISSUE;
      end
      S_ISSUE: begin
        if (!i_busy) begin
          o_enable = 1'b1;
          to_d     = TW'(1);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_done) begin
`ifdef SPI_CODEC_READBACK_EN
          if (rd_q) begin
            rbyte_d = i_data[7:0];
            state_d = S_CHECK;
          end else
`endif
          to_gap = 1'b1;
        end else if (to_q >= TW'(TIMEOUT_CYCLES)) begin
          err_d   = 1'b1;
          code_d  = 2'b01;
          eidx_d  = idx_q;
          state_d = S_FINISH;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q >= GW'(GAP_CYCLES)) advance = 1'b1;
        else gap_d = gap_q + 1'b1;
      end
`ifdef SPI_CODEC_READBACK_EN
      S_CHECK: begin
        if (rbyte_q != entry_w[7:0]) begin
          err_d   = 1'b1;
          code_d  = 2'b10;
          eidx_d  = idx_q;
          state_d = S_FINISH;
        end else begin
          to_gap = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A zero gap skips the GAP state entirely and advances straight away
    if (to_gap) begin
      if (GAP_CYCLES == 0) begin
        advance = 1'b1;
      end else begin
        gap_d   = GW'(1);
        state_d = S_GAP;
      end
    end

    if (advance) begin
`ifdef SPI_CODEC_READBACK_EN
      if (!rd_q && idx_q >= 3'd3) begin
        rd_d    = 1'b1;
        state_d = S_LOAD;
      end else
`endif
      if (idx_q == 3'd7) begin
        state_d = S_FINISH;
      end else begin
        idx_d   = idx_q + 3'd1;
        rd_d    = 1'b0;
        state_d = S_LOAD;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      gap_q   <= '0;
      to_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
      eidx_q  <= '0;
      start_q <= 1'b0;
      arm_q   <= 1'b0;
`ifdef SPI_CODEC_READBACK_EN
      rbyte_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      data_q  <= data_d;
      err_q   <= err_d;
      code_q  <= code_d;
      eidx_q  <= eidx_d;
      start_q <= i_start;
      arm_q   <= arm_q | ~i_start;
`ifdef SPI_CODEC_READBACK_EN
      rbyte_q <= rbyte_d;
`endif
    end
  end

  assign o_data        = data_q;
  assign o_busy        = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign o_done        = (state_q == S_FINISH);
  assign o_error       = err_q;
  assign o_error_code  = code_q;
  assign o_error_index = eidx_q;

endmodule

// File: doc/spi_codec_config_sequencer.md
# spi_codec_config_sequencer

Upstream command source for `spi_master` that programs the audio codec's control registers over SPI after a start request. It walks a fixed 8-entry register table and issues one 32-bit SPI transaction per entry through `spi_master`'s enable/done/busy handshake. Each following transaction is separated by a programmable chip-select gap. The block reports completion, timeout and (optionally) readback-mismatch status for LEDs or a debug core.

## Interface
- `SPI_DATA_WIDTH`, 32: width of SPI word; must be ≥32; bits above 31 driven 0.
- `GAP_CYCLES`, 16: idle i_clock cycles between `i_done` and the next transaction's load; 0 allowed.
- `TIMEOUT_CYCLES`, 4096: max cycles from `o_enable` to `i_done` before abort; ≥1.
- `i_clock`  in  1  system clock (100 MHz); one clock; reset is synchronous and active-high.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_start`  in  1  debounced start request; rising edge starts a sequence.
- `i_data`  in  SPI_DATA_WIDTH  received word from `spi_master`; valid only in the `i_done` cycle.
- `i_done`  in  1  one-cycle transaction-complete pulse from `spi_master`.
- `i_busy`  in  1  `spi_master` busy level.
- `o_enable`  out  1  one-cycle transaction request to `spi_master`.
- `o_data`  out  SPI_DATA_WIDTH  transmit word to `spi_master`.
- `o_busy`  out  1  sequence in progress.
- `o_done`  out  1  sequence finished (success or error); level, held until next start.
- `o_error`  out  1  sequence aborted.
- `o_error_code`  out  2  01 timeout, 10 readback mismatch, 00 none.
- `o_error_index`  out  3  table entry that failed.

## Operation
- Word format: `{7'b0, rw, addr[15:0], data[7:0]}`; rw=0 write, 1 read (data field 0x00; read byte returned in `i_data[7:0]`).
- Table (index: addr/data): 0–2: 0x4000/0x00 (SPI-mode latch dummies); 3: 0x4000/0x01; 4: 0x4015/0x01; 5: 0x4019/0x03; 6: 0x402A/0x03; 7: 0x40F9/0x7F.
- States: IDLE, LOAD, ISSUE, WAIT_DONE, GAP, CHECK (readback only), FINISH.
- IDLE/FINISH: on `i_start` 1 with previous sample 0 → clear status, index=0, → LOAD. Start edges in other states are ignored.
- LOAD: drive `o_data` for current entry → ISSUE.
- ISSUE: if `i_busy`=0, assert `o_enable` for one cycle, clear timeout counter → WAIT_DONE; else stay, `o_enable`=0.
- WAIT_DONE: `o_data` held stable. On `i_done` → GAP (or CHECK phase, see Configuration). If counter reaches TIMEOUT_CYCLES first → FINISH with `o_error`=1, code 01, index latched.
- GAP: count GAP_CYCLES; then index 7 → FINISH, else index+1 → LOAD.
- FINISH: `o_busy`=0, `o_done`=1; error fields hold.
- `i_done` outside WAIT_DONE is ignored.

## Timing
- Reset: state IDLE; `o_enable`, `o_busy`, `o_done`, `o_error`=0; `o_error_code`=00; `o_error_index`=0; `o_data`=0; start-edge register=0.
- Edge sampled at cycle C: `o_busy`=1 and `o_done`=0 at C+1; first `o_enable` at C+2 (if `i_busy`=0).
- `i_done` at cycle D: next entry's `o_enable` at D+GAP_CYCLES+2 (write-only path, `i_busy`=0).
- Last `i_done` at D: `o_done`=1, `o_busy`=0 at D+GAP_CYCLES+1.
- Timeout: `o_enable` at E and no `i_done`: `o_error`=1 at E+TIMEOUT_CYCLES+1.
- `i_done` coincident with the timeout cycle: `i_done` wins, no error.
- Reset mid-sequence: outputs return to reset values next edge; any late `i_done` is ignored in IDLE.

## Configuration
- `SPI_CODEC_READBACK_EN` defined: for entries 3–7, after the write's `i_done` the block passes GAP, then issues a read (rw=1, same addr) through LOAD/ISSUE/WAIT_DONE. On its `i_done` it enters CHECK: `i_data[7:0]` ≠ table data → FINISH, `o_error`=1, code 10, index latched. A match continues via GAP to the next entry. Dummy entries 0–2 are never read back. 13 transactions total.
- Undefined: CHECK state and read transactions are absent; 8 write transactions; code 10 is never produced.

## Test plan
- Reset, no start → all outputs 0 for 100 cycles; `i_start` held high from reset with no prior low → no sequence.
- Start edge, model `spi_master` (`i_done` 40 cycles after `o_enable`), GAP_CYCLES=16 → 8 `o_enable` pulses, `o_data` = 0x00400000, 0x00400000, 0x00400000, 0x00400001, 0x00401501, 0x00401903, 0x00402A03, 0x0040F97F; `o_done`=1, `o_error`=0.
- `i_busy` forced high for 50 cycles at ISSUE of entry 4 → no `o_enable` until `i_busy` falls, then exactly one pulse.
- Suppress `i_done` for entry 5, TIMEOUT_CYCLES=4096 → `o_error`=1, code 01, index 5, at E+4097; no further `o_enable`.
- Readback build, model returns 0x02 for addr 0x4019 → reads issued as 0x01401900; `o_error`=1, code 10, index 5.
- Assert `i_reset` during WAIT_DONE of entry 2, then issue a fresh start edge → restart from entry 0 with `o_data`=0x00400000.
